hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_timeout_counter.sv | 37 +++
 rtl/hazard_control_unit.sv | 149 ++++++++++++++
 tb/tb_hazard_control_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and default constants for the pipeline hazard control unit.
package hazard_pkg;

  // Top-level control FSM states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } hazard_state_t;

  // Default number of IF/ID flush cycles per taken branch (1..7).
  localparam int unsigned BRANCH_SLOTS_DEFAULT = 1;

  // Default consecutive MemBusy cycles before MemError sets (2..255).
  localparam int unsigned MEM_TIMEOUT_DEFAULT  = 16;

  // Width of the slot counter, enough for BRANCH_SLOTS up to 7.
  localparam int unsigned SLOT_W    = 3;

  // Width of the timeout counter, enough for MEM_TIMEOUT up to 255.
  localparam int unsigned TIMEOUT_W = 8;

endpackage

// File: rtl/hazard_timeout_counter.sv
// Saturating counter of consecutive enabled cycles. expired_o is high in the
// cycle whose closing edge brings the count up to (or keeps it at) the limit,
// so a register fed from it sets on exactly that edge.
module hazard_timeout_counter
  import hazard_pkg::*;
#(
  parameter int unsigned WIDTH = TIMEOUT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH:0]   cnt_inc;

  // One extra bit so the increment cannot wrap when the count sits at all-ones.
  assign cnt_inc   = {1'b0, cnt_q} + (WIDTH+1)'(1);
  assign expired_o = enable_i && !clear_i && (cnt_inc >= {1'b0, limit_i});

  // Count enabled cycles, clear on request, hold once the limit is reached.
  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the always blocks are evaluated.
    if (Reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q < limit_i)) begin
      cnt_q <= cnt_inc[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stall, taken-branch flush with a
// configurable number of flush slots, and memory-busy hold with a sticky
// timeout flag. Control outputs are combinational from state and inputs.
// Optional feature: define HAZARD_PERF_EN to build the StallCycles counter;
// without it StallCycles is tied to zero.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned BRANCH_SLOTS = BRANCH_SLOTS_DEFAULT,
  parameter int unsigned MEM_TIMEOUT  = MEM_TIMEOUT_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_Rt,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic        BranchTaken,
  input  logic        MemBusy,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXBubble,
  output logic        MemError,
  output logic [31:0] StallCycles
);

  localparam logic [SLOT_W-1:0]    SLOT_RELOAD = SLOT_W'(BRANCH_SLOTS - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_LIMIT   = TIMEOUT_W'(MEM_TIMEOUT);

  hazard_state_t     state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              mem_error_q;
  logic              load_use;
  logic              flush_mode;
  logic              timeout_hit;

  assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

  // A non-zero slot count in MEM_WAIT means a flush was interrupted and
  // resumes as soon as memory is ready again.
  assign flush_mode = (state_q == FLUSH) ||
                      ((state_q == MEM_WAIT) && (slot_q != '0));

  // Decide this cycle's pipeline controls and the next FSM state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the if/else chain can leave a value unassigned and infer a latch.
    state_d    = state_q;
    slot_d     = slot_q;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;

    if (Reset) begin
      // PC only honours its own reset while write-enabled.
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
      state_d    = RUN;
      slot_d     = '0;
    end else if (MemBusy) begin
      // Freeze the whole front end; slot_q is kept so a flush can resume.
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      state_d   = MEM_WAIT;
    end else if (BranchTaken) begin
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
      if (BRANCH_SLOTS > 1) begin
        state_d = FLUSH;
        slot_d  = SLOT_RELOAD;
      end else begin
        state_d = RUN;
        slot_d  = '0;
      end
    end else if (flush_mode) begin
      // Wrong-path instructions are being zeroed, so a load-use match against
      // the IF/ID contents is meaningless here and is not stalled on.
      IFIDFlush = 1'b1;
      if (slot_q <= SLOT_W'(1)) begin
        state_d = RUN;
        slot_d  = '0;
      end else begin
        state_d = FLUSH;
        slot_d  = slot_q - SLOT_W'(1);
      end
    end else begin
      state_d = RUN;
      if (load_use) begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IDEXBubble = 1'b1;
      end
    end
  end

  // FSM state and flush slot counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  hazard_timeout_counter #(
    .WIDTH (TIMEOUT_W)
  ) u_timeout (
    .Clk       (Clk),
    .Reset     (Reset),
    .enable_i  (MemBusy),
    .clear_i   (!MemBusy),
    .limit_i   (TMO_LIMIT),
    .expired_o (timeout_hit)
  );

  // Sticky memory-timeout flag, cleared only by Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_error_q <= 1'b0;
    end else if (timeout_hit) begin
      mem_error_q <= 1'b1;
    end
  end

  assign MemError = mem_error_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;

  // Count every cycle the PC is held; wraps naturally at 2^32.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cycles_q <= '0;
    end else if (!PCWrite) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign StallCycles = stall_cycles_q;
`else
  assign StallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit (BRANCH_SLOTS=3, MEM_TIMEOUT=4).
// Each cycle the reference model's expected outputs are pushed when inputs
// are driven and popped/compared mid-cycle on the falling edge.
module tb_hazard_control_unit;

  localparam int unsigned SLOTS = 3;
  localparam int unsigned TMO   = 4;

  typedef struct {
    logic        pcw;
    logic        ifw;
    logic        flush;
    logic        bubble;
    logic        err;
    logic [31:0] stall;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_Rt;
  logic [4:0]  IFID_Rs;
  logic [4:0]  IFID_Rt;
  logic        BranchTaken;
  logic        MemBusy;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IFIDFlush;
  logic        IDEXBubble;
  logic        MemError;
  logic [31:0] StallCycles;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Reference model state.
  int          m_flush_left = 0;
  int          m_busy_run   = 0;
  logic        m_err        = 1'b0;
  logic [31:0] m_stall      = 32'd0;

  hazard_control_unit #(
    .BRANCH_SLOTS (SLOTS),
    .MEM_TIMEOUT  (TMO)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .IDEX_MemRead (IDEX_MemRead),
    .IDEX_Rt      (IDEX_Rt),
    .IFID_Rs      (IFID_Rs),
    .IFID_Rt      (IFID_Rt),
    .BranchTaken  (BranchTaken),
    .MemBusy      (MemBusy),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .IFIDFlush    (IFIDFlush),
    .IDEXBubble   (IDEXBubble),
    .MemError     (MemError),
    .StallCycles  (StallCycles)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Drive one cycle of inputs, predict, compare mid-cycle, advance the model.
  task automatic cycle(input logic rst, input logic mr, input logic [4:0] rt,
                       input logic [4:0] rs, input logic [4:0] rtt,
                       input logic br, input logic busy);
    exp_t e;
    exp_t got_e;
    logic lu;
    Reset        = rst;
    IDEX_MemRead = mr;
    IDEX_Rt      = rt;
    IFID_Rs      = rs;
    IFID_Rt      = rtt;
    BranchTaken  = br;
    MemBusy      = busy;

    lu = mr && (rt != 0) && ((rt == rs) || (rt == rtt));
    e.err   = m_err;
    e.stall = m_stall;
    if (rst)                   {e.pcw, e.ifw, e.flush, e.bubble} = 4'b1111;
    else if (busy)             {e.pcw, e.ifw, e.flush, e.bubble} = 4'b0000;
    else if (br)               {e.pcw, e.ifw, e.flush, e.bubble} = 4'b1111;
    else if (m_flush_left > 0) {e.pcw, e.ifw, e.flush, e.bubble} = 4'b1110;
    else if (lu)               {e.pcw, e.ifw, e.flush, e.bubble} = 4'b0001;
    else                       {e.pcw, e.ifw, e.flush, e.bubble} = 4'b1100;
    sb_q.push_back(e);

    @(negedge Clk);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got_e = sb_q.pop_front();
      check("PCWrite",     {31'd0, PCWrite},    {31'd0, got_e.pcw});
      check("IFIDWrite",   {31'd0, IFIDWrite},  {31'd0, got_e.ifw});
      check("IFIDFlush",   {31'd0, IFIDFlush},  {31'd0, got_e.flush});
      check("IDEXBubble",  {31'd0, IDEXBubble}, {31'd0, got_e.bubble});
      check("MemError",    {31'd0, MemError},   {31'd0, got_e.err});
`ifdef HAZARD_PERF_EN
      check("StallCycles", StallCycles, got_e.stall);
`else
      check("StallCycles", StallCycles, 32'd0);
`endif
    end

    @(posedge Clk);
    if (rst) begin
      m_flush_left = 0;
      m_busy_run   = 0;
      m_err        = 1'b0;
      m_stall      = 32'd0;
    end else begin
      if (!e.pcw) m_stall = m_stall + 32'd1;
      if (busy) begin
        if (m_busy_run < TMO) m_busy_run++;
        if (m_busy_run == TMO) m_err = 1'b1;
      end else begin
        m_busy_run = 0;
        if (br) m_flush_left = SLOTS - 1;
        else if (m_flush_left > 0) m_flush_left--;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic busy_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
  endtask

  initial begin
    Reset = 1'b1; IDEX_MemRead = 1'b0; IDEX_Rt = '0; IFID_Rs = '0;
    IFID_Rt = '0; BranchTaken = 1'b0; MemBusy = 1'b0;

    // Reset state, then nominal flow.
    cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(2);

    // Load-use on Rs, on Rt, Rt=0 guard, and a non-matching load.
    cycle(1'b0, 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0);
    idle(1);
    cycle(1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 5'd7, 5'd6, 5'd5, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0);

    // Branch pulse: three flush cycles, PC keeps advancing.
    cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    idle(4);

    // Branch together with MemBusy: busy wins, flush follows the release.
    cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    busy_cycles(1);
    cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    idle(4);

    // MemBusy in mid-flush, then the flush resumes; load-use after it.
    cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    busy_cycles(2);
    idle(2);
    cycle(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
    idle(1);

    // Branch reload while already flushing.
    cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    idle(1);
    cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    idle(4);

    // Busy shorter than the timeout, then exactly the timeout; flag sticks.
    busy_cycles(3);
    idle(1);
    busy_cycles(4);
    idle(3);
    busy_cycles(6);
    idle(2);

    // Reset mid-flush clears everything including the sticky flag.
    cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(2);

    // Random mix of all hazards, with occasional reset.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
